// File: rtl/tri_row_store.sv
`default_nettype none
//==============================================================================
// Module   : tri_row_store
// Triangular complex-matrix store: per-element writes, whole-row reads when full.
// Revision : 1.0
//==============================================================================
module tri_row_store #(
  parameter int SIZE  = 8,
  parameter int WIDTH = 64,
  parameter int LOWER = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      wr_valid_i,
  input  logic [$clog2(SIZE)-1:0]   wr_row_i,
  input  logic [$clog2(SIZE)-1:0]   wr_col_i,
  input  logic [2*WIDTH-1:0]        wr_data_i,
  output logic                      wr_ready_o,
  input  logic                      rd_valid_i,
  input  logic [$clog2(SIZE)-1:0]   rd_addr_i,
  output logic                      rd_valid_o,
  output logic [$clog2(SIZE)-1:0]   rd_addr_o,
  output logic [SIZE*2*WIDTH-1:0]   rd_row_o,
  output logic                      full_o,
  output logic                      singular_o,
  output logic                      err_o
);

  localparam int AW   = $clog2(SIZE);
  localparam int NTRI = SIZE * (SIZE + 1) / 2;
  localparam int CW   = $clog2(NTRI + 1);
  localparam int EW   = 2 * WIDTH;
  localparam logic [AW:0]   SIZE_L = (AW+1)'(SIZE);
  localparam logic [CW-1:0] NTRI_L = CW'(NTRI);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SIZE-1:0]     written_q [SIZE];
  logic [EW-1:0]       mem_q [SIZE][SIZE];
  logic                err_q, err_d;
  logic                rd_valid_q;
  logic [AW-1:0]       rd_addr_q;
  logic [SIZE*EW-1:0]  rd_row_q, rd_row_d;
  logic                wr_in_tri, wr_ok, wr_first, rd_ok;
  logic [SIZE-1:0]     diag_zero;

  // Out-of-range indices (non power-of-two SIZE) count as out-of-triangle.
  function automatic logic in_tri(input logic [AW-1:0] r, input logic [AW-1:0] c);
    logic inb;
    inb = ({1'b0, r} < SIZE_L) && ({1'b0, c} < SIZE_L);
    if (LOWER != 0) return inb && (c <= r);
    else            return inb && (c >= r);
  endfunction

  assign wr_ready_o = (state_q != ST_FULL);
  assign full_o     = (state_q == ST_FULL);
  assign rd_valid_o = rd_valid_q;
  assign rd_addr_o  = rd_addr_q;
  assign rd_row_o   = rd_row_q;
  assign err_o      = err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    wr_in_tri = in_tri(wr_row_i, wr_col_i);
    wr_ok     = wr_valid_i && wr_ready_o && wr_in_tri && !flush_i;
    wr_first  = wr_ok && !written_q[wr_row_i][wr_col_i];
    rd_ok     = rd_valid_i && (state_q == ST_FULL) && !flush_i;

    if (wr_first) cnt_d = cnt_q + CW'(1);

    case (state_q)
      ST_EMPTY:   if (wr_ok) state_d = (cnt_d == NTRI_L) ? ST_FULL : ST_LOADING;
      ST_LOADING: if (cnt_d == NTRI_L) state_d = ST_FULL;
      ST_FULL:    state_d = ST_FULL;
      default:    state_d = ST_EMPTY;
    endcase

    if (wr_valid_i && !(wr_ready_o && wr_in_tri)) err_d = 1'b1;
    if (rd_valid_i && (state_q != ST_FULL))       err_d = 1'b1;

    // Flush wins over everything issued in the same cycle, errors included.
    if (flush_i) begin
      state_d = ST_EMPTY;
      cnt_d   = '0;
      err_d   = 1'b0;
    end
  end

  always_comb begin
    rd_row_d = '0;
    for (int j = 0; j < SIZE; j++) begin
      rd_row_d[j*EW +: EW] = in_tri(rd_addr_i, AW'(j)) ? mem_q[rd_addr_i][j] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_EMPTY;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_row_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rd_valid_q <= rd_ok;
      if (rd_ok) begin
        rd_addr_q <= rd_addr_i;
        rd_row_q  <= rd_row_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      for (int i = 0; i < SIZE; i++) written_q[i] <= '0;
    end else if (wr_ok) begin
      written_q[wr_row_i][wr_col_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_ok) mem_q[wr_row_i][wr_col_i] <= wr_data_i;
  end

  // Sign bits are ignored so that negative zero also counts as zero.
  for (genvar i = 0; i < SIZE; i++) begin : g_diag
    assign diag_zero[i] = (mem_q[i][i][WIDTH-2:0] == '0) &&
                          (mem_q[i][i][EW-2:WIDTH] == '0);
  end

  assign singular_o = full_o && (|diag_zero);

endmodule
`default_nettype wire
